// File: rtl/axil_desc_ram_slave_if.sv
// AXI4-Lite bus bundle between the stimulus master and the descriptor RAM slave.
// The master modport drives requests and the slave modport drives responses.
interface axil_desc_ram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_desc_ram_slave.sv
// AXI4-Lite slave fronting a word-addressed descriptor RAM, with a write-notify port.
// Define AXIL_DESC_UNALIGNED_ERR_EN to reject accesses whose addr[1:0] is nonzero.
module axil_desc_ram_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic                           S_AXI_aclk,
  input  logic                           S_AXI_aresetn,
  axil_desc_ram_slave_if.slave           S_AXI,
  output logic                           wr_notify,
  output logic [$clog2(DEPTH_WORDS)-1:0] wr_index
);
  localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
  localparam int                    NBYTES    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH_WORDS * 4);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;

  logic                  aw_held, w_held, aw_held_n, w_held_n;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [NBYTES-1:0]     w_strb_q;
  logic                  aw_hs, w_hs, ar_hs, commit, b_done;
  logic                  wr_ok, rd_ok;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic                  unused;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    addr_ok = (a >= BASE_ADDR) && (off < WIN_BYTES);
`ifdef AXIL_DESC_UNALIGNED_ERR_EN
    if (a[1:0] != 2'b00) addr_ok = 1'b0;
`endif
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  assign unused = ^{S_AXI.awprot, S_AXI.arprot};
  assign aw_hs  = S_AXI.awvalid && S_AXI.awready;
  assign w_hs   = S_AXI.wvalid && S_AXI.wready;
  assign ar_hs  = S_AXI.arvalid && S_AXI.arready;
  assign wr_ok  = addr_ok(aw_addr_q);
  assign wr_idx = addr_idx(aw_addr_q);
  assign rd_ok  = addr_ok(S_AXI.araddr);
  assign rd_idx = addr_idx(S_AXI.araddr);

  // AW and W are collected independently; the commit fires once both are held.
  always_comb begin
    w_state_n = w_state;
    aw_held_n = aw_held | aw_hs;
    w_held_n  = w_held | w_hs;
    commit    = 1'b0;
    b_done    = 1'b0;
    case (w_state)
      W_IDLE:    if (aw_hs || w_hs) w_state_n = W_COLLECT;
      W_COLLECT: if (aw_held && w_held) begin
        commit    = 1'b1;
        w_state_n = W_RESP;
      end
      W_RESP:    if (S_AXI.bready) begin
        b_done    = 1'b1;
        aw_held_n = 1'b0;
        w_held_n  = 1'b0;
        w_state_n = W_IDLE;
      end
      default:   w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_aclk) begin
    if (!S_AXI_aresetn) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      S_AXI.awready <= 1'b0;
      S_AXI.wready  <= 1'b0;
      S_AXI.bvalid  <= 1'b0;
      S_AXI.bresp   <= RESP_OKAY;
      wr_notify     <= 1'b0;
      wr_index      <= '0;
    end else begin
      w_state       <= w_state_n;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      S_AXI.awready <= !aw_held_n && (w_state_n != W_RESP);
      S_AXI.wready  <= !w_held_n && (w_state_n != W_RESP);
      S_AXI.bvalid  <= (w_state_n == W_RESP);
      wr_notify     <= commit && wr_ok;
      if (aw_hs) aw_addr_q <= S_AXI.awaddr;
      if (w_hs) begin
        w_data_q <= S_AXI.wdata;
        w_strb_q <= S_AXI.wstrb;
      end
      if (commit) begin
        S_AXI.bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) wr_index <= wr_idx;
      end
      if (b_done) begin
        aw_addr_q   <= '0;
        w_data_q    <= '0;
        w_strb_q    <= '0;
        S_AXI.bresp <= RESP_OKAY;
      end
    end
  end

  // A read sampled on the commit edge sees the old word, since both update together.
  always_ff @(posedge S_AXI_aclk) begin
    if (!S_AXI_aresetn) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < NBYTES; b++)
        if (w_strb_q[b]) mem[wr_idx][8*b +: 8] <= w_data_q[8*b +: 8];
    end
  end

  always_comb begin
    r_state_n = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_n = R_RESP;
      R_RESP:  if (S_AXI.rready) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_aclk) begin
    if (!S_AXI_aresetn) begin
      r_state       <= R_IDLE;
      S_AXI.arready <= 1'b0;
      S_AXI.rvalid  <= 1'b0;
      S_AXI.rdata   <= '0;
      S_AXI.rresp   <= RESP_OKAY;
    end else begin
      r_state       <= r_state_n;
      S_AXI.arready <= (r_state_n == R_IDLE);
      if (ar_hs) begin
        S_AXI.rvalid <= 1'b1;
        S_AXI.rdata  <= rd_ok ? mem[rd_idx] : '0;
        S_AXI.rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_state == R_RESP && S_AXI.rready) begin
        S_AXI.rvalid <= 1'b0;
        S_AXI.rdata  <= '0;
        S_AXI.rresp  <= RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axil_desc_ram_slave.sv
// Directed bench for axil_desc_ram_slave: a memory model fills response queues
// as requests are driven, and responses are popped and compared as they arrive.
module tb_axil_desc_ram_slave;
  logic       clk;
  logic       aresetn;
  logic       wr_notify;
  logic [3:0] wr_index;

  int total = 0;
  int bad = 0;
  int notify_cnt = 0;

  logic [31:0] model [16];
  logic [1:0]  b_q [$];
  logic [33:0] r_q [$];

  axil_desc_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_desc_ram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000)
  ) dut (
    .S_AXI_aclk(clk),
    .S_AXI_aresetn(aresetn),
    .S_AXI(bus),
    .wr_notify(wr_notify),
    .wr_index(wr_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (wr_notify === 1'b1) notify_cnt++;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ok(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h1040);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - 32'h1000) >> 2);
  endfunction

  // Full AXI write; reports cycles from the last handshake to bvalid.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           input int bready_delay, output int lat);
    logic       ok, aw_done, w_done, a_now, w_now;
    logic [1:0] exp_resp, held_resp;
    int         cyc, n0;
    ok = model_ok(addr);
    b_q.push_back(ok ? 2'b00 : 2'b10);
    if (ok)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[model_idx(addr)][8*b +: 8] = data[8*b +: 8];
    n0 = notify_cnt;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = (w_lead == 0);
    bus.wvalid  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      a_now = bus.awvalid && bus.awready;
      w_now = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      cyc++;
      if (a_now) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (w_now) begin w_done = 1'b1; bus.wvalid = 1'b0; end
      if (w_lead > 0 && cyc == w_lead) begin
        check_output("w_first_wready_low", {31'd0, bus.wready}, 32'd0);
        check_output("w_first_awready_high", {31'd0, bus.awready}, 32'd1);
        bus.awvalid = 1'b1;
      end
    end
    check_output("wr_handshakes_done", {31'd0, aw_done && w_done}, 32'd1);
    lat = 0;
    while (bus.bvalid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("bvalid_seen", {31'd0, bus.bvalid}, 32'd1);
    check_output("wr_notify_level", {31'd0, wr_notify}, {31'd0, ok});
    if (ok) check_output("wr_index", {28'd0, wr_index}, 32'(model_idx(addr)));
    held_resp = bus.bresp;
    for (int i = 0; i < bready_delay; i++) begin
      @(posedge clk); #1;
      check_output("bvalid_held", {31'd0, bus.bvalid}, 32'd1);
      check_output("bresp_stable", {30'd0, bus.bresp}, {30'd0, held_resp});
      check_output("awready_blocked", {30'd0, bus.awready, bus.wready}, 32'd0);
    end
    exp_resp = b_q.pop_front();
    check_output("bresp", {30'd0, bus.bresp}, {30'd0, exp_resp});
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check_output("bvalid_drop", {31'd0, bus.bvalid}, 32'd0);
    check_output("readies_return", {30'd0, bus.awready, bus.wready}, 32'd3);
    check_output("notify_count", 32'(notify_cnt - n0), ok ? 32'd1 : 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rready_delay);
    logic        ok, done, a_now;
    logic [33:0] exp;
    int          cyc;
    ok = model_ok(addr);
    r_q.push_back(ok ? {2'b00, model[model_idx(addr)]} : {2'b10, 32'd0});
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin
      a_now = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      cyc++;
      if (a_now) begin done = 1'b1; bus.arvalid = 1'b0; end
    end
    check_output("ar_handshake_done", {31'd0, done}, 32'd1);
    cyc = 0;
    while (bus.rvalid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_output("rvalid_seen", {31'd0, bus.rvalid}, 32'd1);
    exp = r_q.pop_front();
    for (int i = 0; i < rready_delay; i++) begin
      @(posedge clk); #1;
      check_output("rdata_stable", bus.rdata, exp[31:0]);
      check_output("arready_blocked", {31'd0, bus.arready}, 32'd0);
    end
    check_output("rdata", bus.rdata, exp[31:0]);
    check_output("rresp", {30'd0, bus.rresp}, {30'd0, exp[33:32]});
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check_output("rvalid_drop", {31'd0, bus.rvalid}, 32'd0);
    check_output("rdata_cleared", bus.rdata, 32'd0);
    check_output("arready_return", {31'd0, bus.arready}, 32'd1);
  endtask

  initial begin
    int lat, cyc;
    logic aw_done, w_done, ar_done, a_now, w_now, r_now;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    aresetn = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
    check_output("rst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    check_output("rst_resps", {28'd0, bus.bresp, bus.rresp}, 32'd0);
    check_output("rst_rdata", bus.rdata, 32'd0);
    check_output("rst_notify", {27'd0, wr_notify, wr_index}, 32'd0);
    aresetn = 1'b1;
    check_output("rst_release_ready_lag", {31'd0, bus.awready}, 32'd0);
    @(posedge clk); #1;
    check_output("rst_release_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);

    $display("[TB] basic write/read");
    axi_write(32'h1000, 32'h0000_1000, 4'hF, 0, 0, lat);
    axi_read(32'h1000, 0);

    $display("[TB] partial strobe");
    axi_write(32'h1008, 32'hC000_0000, 4'hF, 0, 0, lat);
    axi_write(32'h1008, 32'h0000_1234, 4'b0011, 0, 0, lat);
    axi_read(32'h1008, 0);

    $display("[TB] W ahead of AW");
    axi_write(32'h1018, 32'h0C00_0040, 4'hF, 3, 0, lat);
    check_output("w_first_latency", 32'(lat), 32'd1);
    axi_read(32'h1018, 0);

    $display("[TB] out of range");
    axi_write(32'h1040, 32'hFFFF_FFFF, 4'hF, 0, 0, lat);
    axi_read(32'h1040, 0);
    axi_read(32'h1000, 0);
    axi_write(32'h0FFC, 32'h1111_1111, 4'hF, 0, 0, lat);
    axi_write(32'h103C, 32'hA5A5_5A5A, 4'hF, 0, 0, lat);
    axi_read(32'h103C, 0);

    $display("[TB] backpressure");
    axi_write(32'h100C, 32'h5555_AAAA, 4'hF, 0, 5, lat);
    axi_read(32'h100C, 5);

    $display("[TB] reset with responses pending");
    bus.awaddr = 32'h1004; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h1000; bus.arvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0;
    cyc = 0;
    while (!(bus.bvalid === 1'b1 && bus.rvalid === 1'b1) && cyc < 50) begin
      a_now = bus.awvalid && bus.awready;
      w_now = bus.wvalid && bus.wready;
      r_now = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      cyc++;
      if (a_now) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (w_now) begin w_done = 1'b1; bus.wvalid = 1'b0; end
      if (r_now) begin ar_done = 1'b1; bus.arvalid = 1'b0; end
    end
    check_output("pending_both_valid", {30'd0, bus.bvalid, bus.rvalid}, 32'd3);
    aresetn = 1'b0;
    @(posedge clk); #1;
    check_output("mid_rst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'd0);
    check_output("mid_rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
    check_output("mid_rst_notify", {31'd0, wr_notify}, 32'd0);
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    aresetn = 1'b1;
    check_output("mid_rst_ready_lag", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd0);
    @(posedge clk); #1;
    check_output("mid_rst_readies_up", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
    check_output("mid_rst_no_stale_b", {31'd0, bus.bvalid}, 32'd0);
    for (int i = 0; i < 16; i++) axi_read(32'h1000 + 32'(i * 4), 0);

    check_output("b_queue_empty", 32'(b_q.size()), 32'd0);
    check_output("r_queue_empty", 32'(r_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axil_desc_ram_slave.md
Name: axil_desc_ram_slave

Overview:
- Synthesizable AXI4-Lite slave holding a small word-addressed descriptor memory.
- Sits directly downstream of the team's AXI-Lite stimulus master. Answers its writes and reads to the SG descriptor window (default byte base 0x1000).
- Also exposes a one-cycle write-notify port, so a downstream DMA model sees which descriptor word changed.

Parameters:
DATA_WIDTH, 32, data bus width; only 32 is supported.
ADDR_WIDTH, 32, address bus width.
DEPTH_WORDS, 16, number of 32-bit words; must be a power of two, at least 2.
BASE_ADDR, 32'h0000_1000, byte base of the window; aligned to DEPTH_WORDS*4.

Ports:
S_AXI_aclk  in  1  clock
S_AXI_aresetn  in  1  synchronous active-low reset
S_AXI_awaddr  in  ADDR_WIDTH  write address
S_AXI_awprot  in  3  ignored
S_AXI_awvalid  in  1  write address valid
S_AXI_awready  out  1  write address ready
S_AXI_wdata  in  DATA_WIDTH  write data
S_AXI_wstrb  in  DATA_WIDTH/8  byte enables
S_AXI_wvalid  in  1  write data valid
S_AXI_wready  out  1  write data ready
S_AXI_bresp  out  2  00 OKAY, 10 SLVERR
S_AXI_bvalid  out  1  write response valid
S_AXI_bready  in  1  write response ready
S_AXI_araddr  in  ADDR_WIDTH  read address
S_AXI_arprot  in  3  ignored
S_AXI_arvalid  in  1  read address valid
S_AXI_arready  out  1  read address ready
S_AXI_rdata  out  DATA_WIDTH  read data
S_AXI_rresp  out  2  00 OKAY, 10 SLVERR
S_AXI_rvalid  out  1  read data valid
S_AXI_rready  in  1  read data ready
wr_notify  out  1  one-cycle pulse on each committed in-range write
wr_index  out  $clog2(DEPTH_WORDS)  word index of that write; held until the next write

Behaviour:
- Synchronous, active-low reset on S_AXI_aclk. While reset is low:
  - all outputs are 0, including all readies, bresp, rresp, rdata, wr_notify and wr_index;
  - all memory words are cleared to 0.
- Readies are registered. awready, wready and arready first go high on the cycle after aresetn samples 1.
- Decode: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + DEPTH_WORDS*4). Word index = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored.
- Write path, states W_IDLE, W_COLLECT, W_RESP:
  - AW and W are captured independently, in either order or the same cycle.
  - awready is high only while no address is held and the FSM is not in W_RESP. wready follows the same rule for data.
  - A held channel drops its ready on the cycle after its handshake.
  - The cycle after both are held, the write commits: bytes with wstrb=1 are updated, bvalid=1 and bresp is driven. If in_range, bresp=00 and wr_notify pulses for exactly that cycle. Otherwise bresp=10, memory is unchanged and there is no pulse.
  - bvalid holds with stable bresp until bready is sampled high. In the next cycle bvalid=0, the held address and data are cleared, and awready and wready return high.
  - Minimum write latency: one cycle from the last of the AW/W handshakes to bvalid.
- Read path, states R_IDLE, R_RESP:
  - arready is high in R_IDLE. An AR handshake moves to R_RESP with rvalid=1 on the next cycle and arready=0.
  - rdata = mem[index] and rresp=00 if in_range; otherwise rdata=0 and rresp=10.
  - rdata and rresp hold until rready is sampled high. The next cycle returns to R_IDLE: arready=1, rvalid=0, rdata=0.
  - Only one read is outstanding at a time.
- Same-cycle read/write collision: a read whose AR handshake lands on the same edge as a write commit to the same word returns the pre-write value.
- Read and write paths run concurrently and never block each other.
- Reset mid-transaction: pending AW, W, B and R state is dropped. No response is issued for dropped transactions.

Optional Feature:
AXIL_DESC_UNALIGNED_ERR_EN
- Defined: a transaction with addr[1:0] != 0 is treated as out-of-range. It gets SLVERR, no memory update, no wr_notify, and rdata=0.
- Undefined: addr[1:0] is ignored, as specified in Behaviour.

Test Plan:
1. Write 0x1000 = 0x0000_1000, then read 0x1000 -> bresp=00, wr_notify pulse with wr_index=0, rdata=0x0000_1000, rresp=00.
2. Write 0x1008 = 0xC000_0000, then write 0x1008 = 0x0000_1234 with wstrb=4'b0011 -> read returns 0xC000_1234.
3. Drive W 3 cycles before AW (data 0x0C00_0040, addr 0x1018) -> wready pulses first; bvalid 1 cycle after the AW handshake; read returns 0x0C00_0040.
4. Write and read 0x1040 (out of range, DEPTH_WORDS=16) -> bresp=10, no wr_notify, rdata=0, rresp=10; word 0 remains unchanged.
5. Hold bready low 5 cycles after a write -> bvalid stays 1 with stable bresp, awready/wready stay 0, and the next AW is accepted only after the B handshake. Hold rready low 5 cycles -> rdata is stable and arready stays 0.
6. Assert aresetn=0 while bvalid=1 and rvalid=1 -> both are 0 on the next cycle, all words read 0 after release, and readies go high 1 cycle after release.
